multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of the retired-instruction counter.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port opcode  input  7  instruction[6:0], taken from the instruction register.
REQ-005 SHALL have port zero  input  1  ALU zero flag.
REQ-006 SHALL have port mem_ready  input  1  memory completes the current access this cycle.
REQ-007 SHALL have outputs pcwrite, pcwritecond, iord, irwrite, memread, memwrite, memtoreg, regwrite, alusrca, each 1 bit.
REQ-008 SHALL have outputs alusrcb (2 bits), aluop (2 bits) and pcsource (2 bits).
REQ-009 SHALL have outputs trap (1 bit), retire (1 bit), instr_count (CNT_W bits) and state (4 bits), the current-state debug view.

Function
REQ-010 SHALL be a Moore FSM; all control outputs decode from the registered state only, except pcwrite/irwrite gating (REQ-013).
REQ-011 SHALL implement the states and transitions below.
- FETCH -> DECODE.
- DECODE -> MEMADR for LW 0000011 or SW 0100011.
- DECODE -> EXEC_R for 0110011.
- DECODE -> EXEC_I for 0010011.
- DECODE -> BRANCH for 1100011.
- DECODE -> JAL for 1101111.
- DECODE -> TRAP for any other opcode.
- MEMADR -> MEMRD (LW) or MEMWR (SW).
- MEMRD -> MEMWB.
- EXEC_R and EXEC_I -> ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH and JAL -> FETCH.
REQ-012 SHALL hold FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsource=00.
REQ-013 SHALL stay in FETCH, MEMRD or MEMWR while mem_ready=0, keeping every output stable; in FETCH, irwrite and pcwrite SHALL pulse only in the cycle mem_ready=1.
REQ-014 SHALL in DECODE drive alusrca=0, alusrcb=10, aluop=00 (branch-target precompute).
REQ-015 SHALL in MEMADR drive alusrca=1, alusrcb=10, aluop=00.
REQ-016 SHALL in MEMRD drive memread=1, iord=1; in MEMWR drive memwrite=1, iord=1.
REQ-017 SHALL in MEMWB drive regwrite=1, memtoreg=1.
REQ-018 SHALL in EXEC_R drive alusrca=1, alusrcb=00, aluop=10; EXEC_I SHALL match except alusrcb=10.
REQ-019 SHALL in ALUWB drive regwrite=1, memtoreg=0.
REQ-020 SHALL in BRANCH drive alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsource=01; the PC updates only if zero=1.
REQ-021 SHALL in JAL drive pcwrite=1, pcsource=10, regwrite=1, memtoreg=0.
REQ-022 SHALL make TRAP absorbing: trap=1 and every write or enable output 0 until reset.
REQ-023 SHALL drive every output not listed for a state to 0.
REQ-024 SHALL pulse retire for one cycle on the transition out of MEMWB, MEMWR, ALUWB, BRANCH or JAL.
REQ-025 SHALL increment instr_count on each retire and wrap from all-ones to 0 with no flag.
REQ-026 SHALL never assert memread and memwrite together, and never assert regwrite and memwrite together.

Reset
REQ-027 SHALL on reset=0 immediately enter FETCH and clear instr_count, retire and trap, independent of clk.
REQ-028 SHALL abandon any in-progress access when reset is asserted mid-operation (e.g. MEMWR stalled); memwrite SHALL fall asynchronously.
REQ-029 SHALL evaluate FETCH on the first clk edge after reset deasserts.

Structure
REQ-030 SHALL take state encodings, opcode constants and the aluop/alusrcb/pcsource encodings from a shared package, riscv_ctrl_pkg.
REQ-031 SHALL place the counter (REQ-024..025) in the sub-module retire_counter; everything else SHALL be flat.

Verification
REQ-032 SHALL cover: LW (0000011), mem_ready=1 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB (5 cycles); regwrite=1 and memtoreg=1 in MEMWB; instr_count 0->1.
REQ-033 SHALL cover: SW with mem_ready=0 for 3 cycles in MEMWR -> memwrite held 4 cycles; retire=1 exactly once.
REQ-034 SHALL cover: BEQ with zero=0, then with zero=1 -> pcwritecond=1 and aluop=01 both times; 3 cycles each; count +2.
REQ-035 SHALL cover: opcode 1111111 -> TRAP after DECODE; trap stays 1 for 20 cycles of arbitrary stimulus; instr_count frozen.
REQ-036 SHALL cover: reset=0 asserted mid-MEMWR between edges -> memwrite=0 and state=FETCH before the next edge; count=0.
REQ-037 SHALL cover: CNT_W=4, 16 R-type instructions (0110011) -> instr_count wraps 15->0; each takes 4 cycles with regwrite only in ALUWB.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states,
// major opcodes and the ALU/PC mux select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: registers a one-cycle retire pulse and a
// free-running, silently wrapping count of retired instructions.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             retire_event,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset branch gives a known state before any clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire      <= 1'b0;
      instr_count <= '0;
    end else begin
      retire <= retire_event;
      if (retire_event) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle RISC-V datapath (LW/SW/R/I/BEQ/JAL),
// with an absorbing trap state and a retired-instruction counter.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pcwrite,
  output logic             pcwritecond,
  output logic             iord,
  output logic             irwrite,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsource,
  output logic             trap,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state
);

  state_t cur, nxt;
  logic   retire_event;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_EXEC_R;
          OP_ITYPE:     nxt = S_EXEC_I;
          OP_BRANCH:    nxt = S_BRANCH;
          OP_JAL:       nxt = S_JAL;
          default:      nxt = S_TRAP;
        endcase
      end
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_EXEC_R, S_EXEC_I: nxt = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: nxt = S_FETCH;
      S_TRAP:   nxt = S_TRAP;
      default:  nxt = S_TRAP;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REG;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    trap        = 1'b0;
    unique case (cur)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        // PC and IR capture only on the cycle the fetch actually completes.
        pcwrite = mem_ready;
        irwrite = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMM;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_EXEC_R, S_EXEC_I: begin
        alusrca = 1'b1;
        alusrcb = (cur == S_EXEC_I) ? SRCB_IMM : SRCB_REG;
        aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
      end
      S_JAL: begin
        pcwrite  = 1'b1;
        pcsource = PCSRC_JUMP;
        regwrite = 1'b1;
      end
      default: trap = 1'b1;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  assign retire_event = (cur == S_MEMWB) || (cur == S_ALUWB) || (cur == S_BRANCH) ||
                        (cur == S_JAL) || ((cur == S_MEMWR) && mem_ready);
  assign state = cur;

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk          (clk),
    .reset        (reset),
    .retire_event (retire_event),
    .retire       (retire),
    .instr_count  (instr_count)
  );

endmodule
